// File: rtl/seven_pkg.sv
// Shared constants and helpers for the seven_scan display scanner.
package seven_pkg;

  localparam int DIGITS_DEF   = 4;
  localparam int PRESCALE_DEF = 2000;
  localparam int DEAD_DEF     = 4;

  // Segment and decimal-point lines are driven low to light, matching the decoder.
  localparam logic SEG_ACTIVE_LOW = 1'b1;

  function automatic int idx_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/seven_prescale.sv
// Free-running modulo counter: cnt walks 0..MODULUS-1 and tick flags the last count.
module seven_prescale #(
  parameter int MODULUS = 8,
  localparam int W = (MODULUS > 1) ? $clog2(MODULUS) : 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  output logic [W-1:0] cnt,
  output logic         tick
);

  assign tick = (cnt == W'(MODULUS - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seven_scan.sv
// Time-multiplexed, double-buffered scanner for a common-anode 7-segment display.
// Optional leading-zero blanking is enabled by defining SEVEN_SCAN_LZ_BLANK_EN.
module seven_scan
  import seven_pkg::*;
#(
  parameter int DIGITS   = DIGITS_DEF,
  parameter int PRESCALE = PRESCALE_DEF,
  parameter int DEAD     = DEAD_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   data_i,
  input  logic [DIGITS-1:0]     dp_i,
  output logic [3:0]            code_o,
  output logic [DIGITS-1:0]     dig_o,
  output logic                  dp_o,
  output logic                  frame_o
);

  localparam int IW = idx_width(DIGITS);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_next;
  logic                  tick;
  logic                  boundary;

  logic [IW-1:0]         idx, idx_next;
  logic [4*DIGITS-1:0]   shadow_data, shadow_data_next;
  logic [DIGITS-1:0]     shadow_dp, shadow_dp_next;
  logic [4*DIGITS-1:0]   active_data, active_data_next;
  logic [DIGITS-1:0]     active_dp, active_dp_next;
  logic                  pend, pend_next;

  logic [3:0]            nib [DIGITS];
  logic [DIGITS-1:0]     blank;
  logic [3:0]            code_next;
  logic [DIGITS-1:0]     dig_next;
  logic                  dp_next;

  seven_prescale #(.MODULUS(PRESCALE)) u_prescale (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .cnt   (cnt),
    .tick  (tick)
  );

  assign cnt_next = tick ? '0 : cnt + 1'b1;
  assign boundary = tick && (idx == IW'(DIGITS - 1));

  // Index and double-buffer next state; a load on the boundary edge bypasses shadow.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    idx_next         = idx;
    shadow_data_next = shadow_data;
    shadow_dp_next   = shadow_dp;
    active_data_next = active_data;
    active_dp_next   = active_dp;
    pend_next        = pend;

    if (tick) begin
      idx_next = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end

    if (load_i) begin
      shadow_data_next = data_i;
      shadow_dp_next   = dp_i;
      pend_next        = 1'b1;
    end

    if (boundary) begin
      if (load_i) begin
        active_data_next = data_i;
        active_dp_next   = dp_i;
      end else if (pend) begin
        active_data_next = shadow_data;
        active_dp_next   = shadow_dp;
      end
      pend_next = 1'b0;
    end
  end

  // Output values are computed from post-edge state so the output flops carry no extra lag.
  always_comb begin
    for (int k = 0; k < DIGITS; k++) begin
      nib[k] = active_data_next[4*k +: 4];
    end

    blank = '0;
`ifdef SEVEN_SCAN_LZ_BLANK_EN
    begin
      logic zero_above;
      zero_above = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
        zero_above = zero_above && (nib[k] == 4'h0) && !active_dp_next[k];
        blank[k]   = zero_above;
      end
    end
`endif

    code_next = blank[idx_next] ? 4'h0 : nib[idx_next];
    dp_next   = (active_dp_next[idx_next] && !blank[idx_next]) ^ SEG_ACTIVE_LOW;

    dig_next = '1;
    if (en_i && (cnt_next >= CW'(DEAD)) && !blank[idx_next]) begin
      dig_next[idx_next] = 1'b0;
    end
  end

  // NOTE: the buffers are ordinary flops rather than a RAM, so they can and do take a reset value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx         <= '0;
      shadow_data <= '0;
      shadow_dp   <= '0;
      active_data <= '0;
      active_dp   <= '0;
      pend        <= 1'b0;
      code_o      <= 4'h0;
      dig_o       <= '1;
      dp_o        <= SEG_ACTIVE_LOW;
      frame_o     <= 1'b0;
    end else begin
      idx         <= idx_next;
      shadow_data <= shadow_data_next;
      shadow_dp   <= shadow_dp_next;
      active_data <= active_data_next;
      active_dp   <= active_dp_next;
      pend        <= pend_next;
      code_o      <= code_next;
      dig_o       <= dig_next;
      dp_o        <= dp_next;
      frame_o     <= boundary;
    end
  end

endmodule

// File: tb/tb_seven_scan.sv
// Self-checking bench for seven_scan (DIGITS=4, PRESCALE=8, DEAD=2): directed table,
// leading-zero sequence and randomized run against a time-based reference model.
module tb_seven_scan;

  localparam int D = 4;
  localparam int P = 8;
  localparam int DT = 2;

`ifdef SEVEN_SCAN_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif
  // Expected digit enables in slots 1 and 3 while every nibble is zero.
  localparam logic [3:0] Z1 = LZ ? 4'hF : 4'hD;
  localparam logic [3:0] Z3 = LZ ? 4'hF : 4'h7;

  logic          clk_i = 1'b0;
  logic          rst_i, en_i, load_i;
  logic [15:0]   data_i;
  logic [3:0]    dp_i;
  logic [3:0]    code_o;
  logic [3:0]    dig_o;
  logic          dp_o, frame_o;

  int tests = 0;
  int fails = 0;

  // Reference model: t = edges since the last reset edge; active content changes only at frame edges.
  int            t;
  logic [15:0]   m_last, m_active;
  logic [3:0]    m_last_dp, m_active_dp;
  logic [3:0]    e_code, e_dig;
  logic          e_dp, e_frame;

  seven_scan #(.DIGITS(D), .PRESCALE(P), .DEAD(DT)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (en_i),
    .load_i  (load_i),
    .data_i  (data_i),
    .dp_i    (dp_i),
    .code_o  (code_o),
    .dig_o   (dig_o),
    .dp_o    (dp_o),
    .frame_o (frame_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at t=%0d: got %h, expected %h", name, t, got, exp);
    end
  endtask

  task automatic model_edge();
    int slot, cnt;
    logic [3:0] nib;
    logic blank;
    if (rst_i) begin
      t = 0;
      m_last = '0; m_last_dp = '0; m_active = '0; m_active_dp = '0;
      e_code = 4'h0; e_dig = 4'hF; e_dp = 1'b1; e_frame = 1'b0;
    end else begin
      t++;
      if (load_i) begin
        m_last = data_i;
        m_last_dp = dp_i;
      end
      e_frame = (t % (P * D)) == 0;
      if (e_frame) begin
        m_active = m_last;
        m_active_dp = m_last_dp;
      end
      cnt  = t % P;
      slot = (t / P) % D;
      nib  = 4'((m_active >> (4 * slot)) & 16'hF);
      blank = LZ && slot > 0 && (m_active >> (4 * slot)) == 0 && (m_active_dp >> slot) == 0;
      e_code = blank ? 4'h0 : nib;
      e_dp   = !m_active_dp[slot];
      e_dig  = (en_i && cnt >= DT && !blank) ? ~(4'b0001 << slot) : 4'hF;
    end
  endtask

  // One clock: model consumes the inputs present at the edge, outputs sampled 1ns later.
  task automatic step();
    @(posedge clk_i);
    model_edge();
    #1;
    check("code_o", 32'(code_o), 32'(e_code));
    check("dig_o", 32'(dig_o), 32'(e_dig));
    check("dp_o", 32'(dp_o), 32'(e_dp));
    check("frame_o", 32'(frame_o), 32'(e_frame));
  endtask

  task automatic drive(input logic rst, input logic en, input logic load,
                       input logic [15:0] data, input logic [3:0] dp);
    rst_i = rst; en_i = en; load_i = load; data_i = data; dp_i = dp;
  endtask

  // Steps with idle inputs until the model reaches time target (bounded).
  task automatic run_to(input int target);
    for (int n = 0; n < 200 && t != target; n++) begin
      drive(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
      step();
    end
    check("run_to_reached", 32'(t), 32'(target));
  endtask

  typedef struct {
    int          cycles;
    logic        rst, en, load;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  code;
    logic [3:0]  dig;
    logic        dpo;
    logic        frame;
  } vec_t;

  vec_t vecs[28];

  initial begin
    //            cyc rst en ld data      dp     code  dig   dpo frame
    vecs[0]  = '{1,  1, 0, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 1, 0};
    vecs[1]  = '{1,  0, 1, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 1, 0};
    vecs[2]  = '{1,  0, 1, 0, 16'h0000, 4'h0, 4'h0, 4'hE, 1, 0};
    vecs[3]  = '{5,  0, 1, 0, 16'h0000, 4'h0, 4'h0, 4'hE, 1, 0};
    vecs[4]  = '{1,  0, 1, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 1, 0};
    vecs[5]  = '{2,  0, 1, 0, 16'h0000, 4'h0, 4'h0, Z1,   1, 0};
    vecs[6]  = '{1,  0, 1, 1, 16'h1234, 4'h4, 4'h0, Z1,   1, 0};
    vecs[7]  = '{20, 0, 1, 0, 16'h0000, 4'h0, 4'h0, Z3,   1, 0};
    vecs[8]  = '{1,  0, 1, 0, 16'h0000, 4'h0, 4'h4, 4'hF, 1, 1};
    vecs[9]  = '{2,  0, 1, 0, 16'h0000, 4'h0, 4'h4, 4'hE, 1, 0};
    vecs[10] = '{8,  0, 1, 0, 16'h0000, 4'h0, 4'h3, 4'hD, 1, 0};
    vecs[11] = '{8,  0, 1, 0, 16'h0000, 4'h0, 4'h2, 4'hB, 0, 0};
    vecs[12] = '{8,  0, 1, 0, 16'h0000, 4'h0, 4'h1, 4'h7, 1, 0};
    vecs[13] = '{5,  0, 1, 0, 16'h0000, 4'h0, 4'h1, 4'h7, 1, 0};
    vecs[14] = '{1,  0, 1, 1, 16'hABCD, 4'h0, 4'hD, 4'hF, 1, 1};
    vecs[15] = '{2,  0, 1, 0, 16'h0000, 4'h0, 4'hD, 4'hE, 1, 0};
    vecs[16] = '{1,  0, 1, 1, 16'h1111, 4'h0, 4'hD, 4'hE, 1, 0};
    vecs[17] = '{10, 0, 1, 0, 16'h0000, 4'h0, 4'hC, 4'hD, 1, 0};
    vecs[18] = '{1,  0, 1, 1, 16'h2222, 4'h0, 4'hC, 4'hD, 1, 0};
    vecs[19] = '{17, 0, 1, 0, 16'h0000, 4'h0, 4'hA, 4'h7, 1, 0};
    vecs[20] = '{1,  0, 1, 0, 16'h0000, 4'h0, 4'h2, 4'hF, 1, 1};
    vecs[21] = '{10, 0, 1, 0, 16'h0000, 4'h0, 4'h2, 4'hD, 1, 0};
    vecs[22] = '{20, 0, 0, 0, 16'h0000, 4'h0, 4'h2, 4'hF, 1, 0};
    vecs[23] = '{1,  0, 1, 0, 16'h0000, 4'h0, 4'h2, 4'h7, 1, 0};
    vecs[24] = '{1,  0, 1, 0, 16'h0000, 4'h0, 4'h2, 4'hF, 1, 1};
    vecs[25] = '{18, 0, 1, 0, 16'h0000, 4'h0, 4'h2, 4'hB, 1, 0};
    vecs[26] = '{1,  1, 1, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 1, 0};
    vecs[27] = '{10, 0, 1, 0, 16'h0000, 4'h0, 4'h0, Z1,   1, 0};

    t = 0;
    drive(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
    #1;

    // Directed table; the model also checks every cycle along the way.
    for (int i = 0; i < 28; i++) begin
      for (int c = 0; c < vecs[i].cycles; c++) begin
        drive(vecs[i].rst, vecs[i].en, vecs[i].load, vecs[i].data, vecs[i].dp);
        step();
      end
      check($sformatf("vec%0d_code", i), 32'(code_o), 32'(vecs[i].code));
      check($sformatf("vec%0d_dig", i), 32'(dig_o), 32'(vecs[i].dig));
      check($sformatf("vec%0d_dp", i), 32'(dp_o), 32'(vecs[i].dpo));
      check($sformatf("vec%0d_frame", i), 32'(frame_o), 32'(vecs[i].frame));
    end

    // Leading-zero sequence: 0042 with no decimal points, then all zeros.
    drive(1'b0, 1'b1, 1'b1, 16'h0042, 4'h0);
    step();
    run_to(36);
    check("lz0042_s0_code", 32'(code_o), 32'h2);
    check("lz0042_s0_dig", 32'(dig_o), 32'hE);
    run_to(44);
    check("lz0042_s1_code", 32'(code_o), 32'h4);
    check("lz0042_s1_dig", 32'(dig_o), 32'hD);
    run_to(52);
    check("lz0042_s2_dig", 32'(dig_o), LZ ? 32'hF : 32'hB);
    run_to(60);
    check("lz0042_s3_dig", 32'(dig_o), 32'(Z3));
    drive(1'b0, 1'b1, 1'b1, 16'h0000, 4'h0);
    step();
    run_to(68);
    check("lz0000_s0_dig", 32'(dig_o), 32'hE);
    run_to(76);
    check("lz0000_s1_dig", 32'(dig_o), 32'(Z1));

    // Randomized run against the model.
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 9) == 0), 16'($urandom), 4'($urandom));
      if ($urandom_range(0, 3) == 0) data_i &= 16'h00FF;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
